imem_miss_responder: RTL and testbench

- Main-memory side of the instruction-cache refill handshake.
- Watches the cache's HitWrite stall signal. On a miss it captures the word address from PC and waits a programmable memory latency.
- It then returns the instruction word on Data_MM with a one-cycle Access_MM pulse, which the cache uses to fill its FIFO slot.
- Holds a word-addressed backing store, preloadable through a load port.

---
 rtl/imem_miss_responder.sv | 110 +++++++++++
 tb/tb_imem_miss_responder.sv | 222 ++++++++++++++++++++++
 2 files changed

// File: rtl/imem_miss_responder.sv
// Main-memory responder for instruction-cache refills, with a preloadable word-addressed backing store.
// Optional macro MM_RANGE_CHECK_EN flags out-of-range fetch addresses on MM_ERR.
module imem_miss_responder #(
    parameter int DEPTH   = 1024,
    parameter int LATENCY = 4,
    parameter int AW      = 10
) (
    input  logic          CLK,
    input  logic          RESET,
    input  logic [31:0]   PC,
    input  logic          HitWrite,
    output logic          Access_MM,
    output logic [31:0]   Data_MM,
    output logic          BUSY,
    output logic          MM_ERR,
    output logic [19:0]   CNT_REQ,
    input  logic          LOAD_EN,
    input  logic [AW-1:0] LOAD_ADDR,
    input  logic [31:0]   LOAD_DATA,
    output logic [1:0]    state_dbg
);

    // Handshake: HitWrite==0 sampled in IDLE is a request; Access_MM is a
    // single-cycle strobe with Data_MM valid in that cycle; no backpressure.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } state_t;

    localparam logic [3:0] LAT_M1 = 4'(LATENCY - 1);

    state_t        state;
    logic [3:0]    cnt;
    logic [AW-1:0] addr;
    logic [31:0]   mem [DEPTH];
    logic [31:0]   rd_word;
    logic          miss_now;
    logic          unused_pc;

    assign state_dbg = state;
    assign miss_now  = (state == IDLE) && (HitWrite == 1'b0);
    assign unused_pc = ^{PC[31:AW+2], PC[1:0]};

    // Backing store is never reset; the read in the FSM sees the pre-write word.
    always_ff @(posedge CLK) begin
        if (LOAD_EN)
            mem[LOAD_ADDR] <= LOAD_DATA;
    end

`ifdef MM_RANGE_CHECK_EN
    logic oor;

    always_ff @(posedge CLK) begin
        if (!RESET) begin
            oor    <= 1'b0;
            MM_ERR <= 1'b0;
        end else if (miss_now) begin
            oor    <= |PC[31:AW+2];
            MM_ERR <= MM_ERR | (|PC[31:AW+2]);
        end
    end

    assign rd_word = oor ? 32'h0000_0000 : mem[addr];
`else
    assign MM_ERR  = 1'b0;
    assign rd_word = mem[addr];
`endif

    always_ff @(posedge CLK) begin
        if (!RESET) begin
            state     <= IDLE;
            Access_MM <= 1'b0;
            Data_MM   <= 32'h0000_0000;
            BUSY      <= 1'b0;
            CNT_REQ   <= 20'd0;
            cnt       <= 4'd0;
            addr      <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (miss_now) begin
                        addr  <= PC[AW+1:2];
                        cnt   <= LAT_M1;
                        BUSY  <= 1'b1;
                        state <= WAIT;
                    end
                end
                WAIT: begin
                    if (cnt != 4'd0) begin
                        cnt <= cnt - 4'd1;
                    end else begin
                        Data_MM   <= rd_word;
                        Access_MM <= 1'b1;
                        CNT_REQ   <= CNT_REQ + 20'd1;
                        state     <= RESP;
                    end
                end
                RESP: begin
                    // The cache raises HitWrite on this same edge, so it is not sampled here.
                    Access_MM <= 1'b0;
                    BUSY      <= 1'b0;
                    state     <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_imem_miss_responder.sv
// Scoreboard bench for imem_miss_responder: drivers push expected refills, a monitor checks each Access_MM pulse.
module tb_imem_miss_responder;

    localparam int LAT = 4;
    localparam int AW  = 10;

    logic          clk;
    logic          reset_n;
    logic [31:0]   pc;
    logic          hit_write;
    logic          access_mm;
    logic [31:0]   data_mm;
    logic          busy;
    logic          mm_err;
    logic [19:0]   cnt_req;
    logic          load_en;
    logic [AW-1:0] load_addr;
    logic [31:0]   load_data;
    logic [1:0]    state_dbg;

    int cyc = 0;
    int n_cmp = 0;
    int n_err = 0;
    int exp_cnt = 0;

    logic [31:0] exp_q[$];
    int          exp_cyc_q[$];

    imem_miss_responder #(.DEPTH(1024), .LATENCY(LAT), .AW(AW)) dut (
        .CLK       (clk),
        .RESET     (reset_n),
        .PC        (pc),
        .HitWrite  (hit_write),
        .Access_MM (access_mm),
        .Data_MM   (data_mm),
        .BUSY      (busy),
        .MM_ERR    (mm_err),
        .CNT_REQ   (cnt_req),
        .LOAD_EN   (load_en),
        .LOAD_ADDR (load_addr),
        .LOAD_DATA (load_data),
        .state_dbg (state_dbg)
    );

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // ---------------- checking ----------------
    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Monitor: every Access_MM cycle must match the head of the scoreboard.
    always @(negedge clk) begin
        if (access_mm === 1'b1) begin
            if (exp_q.size() == 0) begin
                check("unexpected_pulse", 32'd1, 32'd0);
            end else begin
                check("pulse_data", data_mm, exp_q.pop_front());
                check("pulse_cycle", 32'(cyc), 32'(exp_cyc_q.pop_front()));
            end
        end
    end

    // ---------------- drivers ----------------
    task automatic push_exp(input logic [31:0] d, input int c);
        exp_q.push_back(d);
        exp_cyc_q.push_back(c);
        exp_cnt++;
    endtask

    task automatic load_word(input logic [AW-1:0] a, input logic [31:0] d);
        @(negedge clk);
        load_en   = 1'b1;
        load_addr = a;
        load_data = d;
        @(negedge clk);
        load_en   = 1'b0;
    endtask

    // Presents a miss for one edge; t returns the capture edge index.
    task automatic miss(input logic [31:0] a, output int t);
        @(negedge clk);
        pc        = a;
        hit_write = 1'b0;
        t         = cyc + 1;
        @(negedge clk);
        hit_write = 1'b1;
    endtask

    task automatic wait_until(input int c);
        int guard = 0;
        while (cyc < c && guard < 1000) begin
            @(negedge clk);
            guard++;
        end
    endtask

    // ---------------- stimulus ----------------
    initial begin
        int t;
        reset_n   = 1'b0;
        pc        = $urandom;
        hit_write = 1'($urandom_range(0, 1));
        load_en   = 1'($urandom_range(0, 1));
        load_addr = AW'($urandom);
        load_data = $urandom;
        @(negedge clk);
        check("rst_access", {31'd0, access_mm}, 32'd0);
        check("rst_data", data_mm, 32'd0);
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_err", {31'd0, mm_err}, 32'd0);
        check("rst_cnt", {12'd0, cnt_req}, 32'd0);
        check("rst_state", {30'd0, state_dbg}, 32'd0);
        pc        = $urandom;
        hit_write = 1'($urandom_range(0, 1));
        @(negedge clk);
        reset_n   = 1'b1;
        hit_write = 1'b1;
        load_en   = 1'b0;

        load_word(10'd3, 32'hDEADBEEF);
        load_word(10'd4, 32'hCAFEF00D);
        load_word(10'd0, 32'h12345678);
        load_word(10'd5, 32'h55550005);

        // Basic refill of mem[3], PC changed during WAIT.
        miss(32'h0000_000C, t);
        push_exp(32'hDEADBEEF, t + LAT);
        check("busy_wait", {31'd0, busy}, 32'd1);
        pc = 32'h0000_0010;
        wait_until(t + LAT + 2);
        check("cnt_after_1", {12'd0, cnt_req}, 32'(exp_cnt));
        check("busy_after_1", {31'd0, busy}, 32'd0);
        check("data_hold", data_mm, 32'hDEADBEEF);

        // HitWrite held low through RESP, raised before IDLE samples it: single pulse.
        @(negedge clk);
        pc        = 32'h0000_0010;
        hit_write = 1'b0;
        t         = cyc + 1;
        push_exp(32'hCAFEF00D, t + LAT);
        wait_until(t + LAT + 1);
        hit_write = 1'b1;
        wait_until(t + LAT + 8);
        check("cnt_single", {12'd0, cnt_req}, 32'(exp_cnt));

        // HitWrite kept low after RESP: second refill, LATENCY+1 idle cycles between pulses.
        @(negedge clk);
        pc        = 32'h0000_000C;
        hit_write = 1'b0;
        t         = cyc + 1;
        push_exp(32'hDEADBEEF, t + LAT);
        push_exp(32'hDEADBEEF, t + 2 * LAT + 2);
        wait_until(t + LAT + 2);
        hit_write = 1'b1;
        wait_until(t + 2 * LAT + 4);
        check("cnt_b2b", {12'd0, cnt_req}, 32'(exp_cnt));

        // Reset at capture+2 aborts the refill.
        miss(32'h0000_000C, t);
        wait_until(t + 1);
        reset_n = 1'b0;
        @(negedge clk);
        check("abort_state", {30'd0, state_dbg}, 32'd0);
        check("abort_busy", {31'd0, busy}, 32'd0);
        check("abort_cnt", {12'd0, cnt_req}, 32'd0);
        check("abort_data", data_mm, 32'd0);
        reset_n = 1'b1;
        exp_cnt = 0;
        repeat (LAT + 4) @(negedge clk);

        // Load to the address read on the WAIT->RESP edge returns the old word.
        miss(32'h0000_0014, t);
        push_exp(32'h55550005, t + LAT);
        wait_until(t + LAT - 1);
        load_en   = 1'b1;
        load_addr = 10'd5;
        load_data = 32'hAAAA0005;
        @(negedge clk);
        load_en   = 1'b0;
        repeat (3) @(negedge clk);
        miss(32'h0000_0014, t);
        push_exp(32'hAAAA0005, t + LAT);
        wait_until(t + LAT + 2);

        // Upper PC bits set.
        miss(32'h0000_1000, t);
`ifdef MM_RANGE_CHECK_EN
        push_exp(32'h0000_0000, t + LAT);
        wait_until(t + LAT + 2);
        check("err_set", {31'd0, mm_err}, 32'd1);
        miss(32'h0000_0000, t);
        push_exp(32'h12345678, t + LAT);
        wait_until(t + LAT + 2);
        check("err_sticky", {31'd0, mm_err}, 32'd1);
`else
        push_exp(32'h12345678, t + LAT);
        wait_until(t + LAT + 2);
        check("err_tied", {31'd0, mm_err}, 32'd0);
`endif
        check("cnt_final", {12'd0, cnt_req}, 32'(exp_cnt));

        repeat (4) @(negedge clk);
        check("queue_drained", 32'(exp_q.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1);
    end

endmodule
